// File: rtl/vga_pixel_if.sv
// Pixel request / colour return channel between vga_timing_gen (master)
// and a pixel source (slave) such as a ROM, SRAM or test-pattern block.
interface vga_pixel_if #(
   parameter int COLOR_W = 10,
   parameter int ADDR_W  = 22
);
   logic               o_request;
   logic [10:0]        o_x;
   logic [10:0]        o_y;
   logic [ADDR_W-1:0]  o_address;
   logic               o_frame_start;
   logic               o_line_start;
   logic [COLOR_W-1:0] i_red;
   logic [COLOR_W-1:0] i_green;
   logic [COLOR_W-1:0] i_blue;

   modport master (
      output o_request, o_x, o_y, o_address, o_frame_start, o_line_start,
      input  i_red, i_green, i_blue
   );

   modport slave (
      input  o_request, o_x, o_y, o_address, o_frame_start, o_line_start,
      output i_red, i_green, i_blue
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and pixel-request generator; returned colour is
// re-aligned with sync and blank through a LEAD-deep control pipeline.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int LEAD     = 1,
   parameter int COLOR_W  = 10,
   parameter int ADDR_W   = 22
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_enable,
   vga_pixel_if.master        pix,
   output logic [COLOR_W-1:0] o_vga_r,
   output logic [COLOR_W-1:0] o_vga_g,
   output logic [COLOR_W-1:0] o_vga_b,
   output logic               o_hs,
   output logic               o_vs,
   output logic               o_blank_n,
   output logic               o_sync_n
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } ctl_t;

   logic              en_q;
   logic [10:0]       h_cnt_q, h_cnt_d;
   logic [10:0]       v_cnt_q, v_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              run, h_last, v_last, active, last_px, hs_raw, vs_raw;
   ctl_t              cur, tap;

   logic [COLOR_W-1:0] vga_r_q, vga_g_q, vga_b_q;
   logic               hs_q, vs_q, blank_n_q;

   // Counters advance only while enable was and still is high, so dropping
   // i_enable zeroes them on the same edge that clears en_q.
   assign run    = i_enable && en_q;
   assign h_last = (h_cnt_q == 11'(H_TOTAL - 1));
   assign v_last = (v_cnt_q == 11'(V_TOTAL - 1));
   assign active = en_q && (h_cnt_q < 11'(H_ACTIVE)) && (v_cnt_q < 11'(V_ACTIVE));
   assign last_px = active && (h_cnt_q == 11'(H_ACTIVE - 1)) && (v_cnt_q == 11'(V_ACTIVE - 1));
   assign hs_raw = en_q && (h_cnt_q >= 11'(H_ACTIVE + H_FP)) &&
                   (h_cnt_q < 11'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_raw = en_q && (v_cnt_q >= 11'(V_ACTIVE + V_FP)) &&
                   (v_cnt_q < 11'(V_ACTIVE + V_FP + V_SYNC));

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      h_cnt_d = '0;
      v_cnt_d = '0;
      addr_d  = '0;
      if (run) begin
         h_cnt_d = h_last ? '0 : h_cnt_q + 11'd1;
         v_cnt_d = v_cnt_q;
         if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 11'd1;
         addr_d  = addr_q;
         if (active) addr_d = last_px ? '0 : addr_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!i_rst_n) begin
         en_q    <= 1'b0;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         addr_q  <= '0;
      end else begin
         en_q    <= i_enable;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         addr_q  <= addr_d;
      end
   end

   assign pix.o_request     = active;
   assign pix.o_x           = h_cnt_q;
   assign pix.o_y           = v_cnt_q;
   assign pix.o_address     = addr_q;
   assign pix.o_line_start  = en_q && (h_cnt_q == '0) && (v_cnt_q < 11'(V_ACTIVE));
   assign pix.o_frame_start = en_q && (h_cnt_q == '0) && (v_cnt_q == '0);

   assign cur = '{active: active, hs: hs_raw, vs: vs_raw};

   generate
      if (LEAD == 0) begin : g_no_pipe
         assign tap = cur;
      end else begin : g_pipe
         ctl_t pipe_q [LEAD];
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            // NOTE: this shift register holds only control flags, so it is
            // reset; a stale active bit would otherwise unblank garbage.
            if (!i_rst_n) begin
               for (int i = 0; i < LEAD; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= cur;
               for (int i = 1; i < LEAD; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end
         assign tap = pipe_q[LEAD-1];
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vga_r_q   <= '0;
         vga_g_q   <= '0;
         vga_b_q   <= '0;
         hs_q      <= ~HS_POL;
         vs_q      <= ~VS_POL;
         blank_n_q <= 1'b0;
      end else begin
         vga_r_q   <= tap.active ? pix.i_red   : '0;
         vga_g_q   <= tap.active ? pix.i_green : '0;
         vga_b_q   <= tap.active ? pix.i_blue  : '0;
         hs_q      <= tap.hs ? HS_POL : ~HS_POL;
         vs_q      <= tap.vs ? VS_POL : ~VS_POL;
         blank_n_q <= tap.active;
      end
   end

   assign o_vga_r   = vga_r_q;
   assign o_vga_g   = vga_g_q;
   assign o_vga_b   = vga_b_q;
   assign o_hs      = hs_q;
   assign o_vs      = vs_q;
   assign o_blank_n = blank_n_q;
   assign o_sync_n  = 1'b0;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing and pixel-request generator, the successor to the fixed 640x480 controller between the pixel sources (`scroll`, test patterns) and the DE2-115 VGA DAC pins. It produces pixel coordinates, a linear frame-buffer address and a request strobe. It then aligns the returned colour with sync and blank through a pipeline of configurable depth. This lets pixel sources with multi-cycle latency (ROM, SRAM) be attached without external delay matching.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal front porch, sync and back porch, in pixel clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10; V_SYNC, 2; V_BP, 33: vertical front porch, sync and back porch, in lines
- HS_POL, 0; VS_POL, 0: active level of the sync pulse (0 = active-low)
- LEAD, 1: cycles from `o_request` to valid colour on `i_red/i_green/i_blue` (range 0..4)
- COLOR_W, 10: width of each colour channel
- ADDR_W, 22: width of `o_address`
- i_clk  in  1  pixel clock (25 MHz for the default parameters); one clock domain only
- i_rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  timing runs while high
- i_red, i_green, i_blue  in  COLOR_W each  pixel colour, valid LEAD cycles after the matching request
- o_request  out  1  the current (o_x, o_y) is a visible pixel and its colour is requested
- o_x, o_y  out  11 each  coordinates of the request; valid while `o_request` is high
- o_address  out  ADDR_W  o_y*H_ACTIVE + o_x
- o_frame_start, o_line_start  out  1  one-cycle pulses at (0,0) and at x=0 of each visible line
- o_vga_r, o_vga_g, o_vga_b  out  COLOR_W each  registered colour to the DAC
- o_hs, o_vs  out  1  registered sync outputs
- o_blank_n  out  1  registered; high while the DAC output is visible
- o_sync_n  out  1  held at 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line order is active, front porch, sync, back porch, so h_cnt=0 is the first visible pixel. Frames use the same order.
- Register `en_q` follows `i_enable`. While `en_q`=0:
  - h_cnt, v_cnt and the address counter are held at 0.
  - `o_request`, `o_frame_start` and `o_line_start` are 0.
- While `en_q`=1:
  - h_cnt increments each cycle and wraps at H_TOTAL-1.
  - v_cnt increments on the h wrap and wraps at V_TOTAL-1.
- Active region: `o_request` = en_q && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. `o_x`=h_cnt and `o_y`=v_cnt, driven from the counter registers.
- Address counter:
  - Incremented on every request cycle, not computed with a multiplier.
  - Returns to 0 after the cycle that requests (H_ACTIVE-1, V_ACTIVE-1), and whenever `en_q`=0.
- Sync raw values:
  - hs_raw is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is active for whole lines V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - Both are gated by en_q; when en_q=0 they are inactive.
- Sync output levels: the active level equals HS_POL / VS_POL and the inactive level is its complement.
- Pipeline: the signals {active, hs_raw, vs_raw} pass through a LEAD-stage shift register.
- Output register: at the end of the LEAD stages, colour is captured when the delayed active flag is 1, and forced to 0 otherwise.
- Reset values:
  - All counters, `en_q` and pipeline stages are 0.
  - `o_request`, `o_frame_start`, `o_line_start`, `o_address`, `o_x`, `o_y`, colour outputs and `o_blank_n` are 0.
  - `o_hs` and `o_vs` are at their inactive levels.
  - Reset takes effect asynchronously, without a clock edge.
- Dropping `i_enable` mid-frame:
  - `en_q` clears on the next edge and the counters return to 0 on that same edge.
  - The pipeline keeps shifting and drains blank and inactive sync within LEAD+1 cycles.
- Re-enabling restarts at (0,0) with an `o_frame_start` pulse.

## Timing
- The request at cycle t appears on `o_vga_*`, `o_hs`, `o_vs` and `o_blank_n` at cycle t+LEAD+1. Sync and colour always stay mutually aligned.
- With LEAD=0, `i_*` is sampled in the same cycle as the request.
- After reset is released with `i_enable`=1, the first edge sets `en_q`. From that edge `o_request`=1 with (0,0) and `o_frame_start`=1.
- `o_line_start` is high when h_cnt=0 && v_cnt<V_ACTIVE && en_q. `o_frame_start` coincides with the `o_line_start` for line 0.
- Default parameters: line = 800 cycles, frame = 420000 cycles, `o_hs` active for 96 cycles per line, `o_vs` active for 1600 cycles per frame.

## Test plan
- Default parameters, LEAD=1, free run for 2 frames:
  - 307200 `o_request` cycles per frame.
  - `o_hs` low exactly at h_cnt 656..751 (delayed 2 cycles).
  - `o_vs` low for 1600 cycles.
  - `o_frame_start` period = 420000 cycles.
- LEAD=2, source drives i_red = o_x delayed 2 cycles:
  - `o_vga_r` at t+3 equals the o_x requested at t.
  - `o_blank_n` is high for exactly 640 consecutive cycles per visible line.
  - Colour is 0 during blanking even if `i_red` is nonzero.
- Address checks:
  - `o_address` is 639 at (639,0), 640 at (0,1) and 307199 at (639,479).
  - It is 0 at the next (0,0).
- `i_enable` dropped at (100,10):
  - After the next edge, `o_request`=0 and `o_x`=`o_y`=0.
  - Outputs are blank with inactive sync within 3 cycles.
  - After re-enable, the first request is at (0,0) with `o_frame_start`=1.
- Tiny configuration (H 4/1/1/1, V 2/1/1/1, HS_POL=1, LEAD=0):
  - Frame is 35 cycles.
  - `o_hs` is high for 1 cycle per line, one cycle after h_cnt=5.
  - 8 requests per frame.
- Asynchronous reset asserted mid-frame between clock edges:
  - All outputs take their reset values immediately.
  - After release, counting restarts at (0,0).
